// File: rtl/riscv_core_pkg.sv
// rtl/riscv_core_pkg.sv - shared core constants: data width, opcodes, NOP encoding
package riscv_core_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational sign-extended immediate decode for load, store and branch
module imm_gen
  import riscv_core_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_instr[6:0])
      OP_LOAD:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OP_STORE:  o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      // Branch offsets are halfword-scaled, so bit 0 is always zero.
      OP_BRANCH: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      default:   o_imm = '0;
    endcase
  end

endmodule

// File: rtl/pc_ir_unit.sv
// rtl/pc_ir_unit.sv - PC, instruction register, MDR and ALU-out registers of a multicycle core
// Optional fetch counter on instrCount is built when PC_IR_INSTR_CNT_EN is defined.
module pc_ir_unit
  import riscv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcWriteEnable,
  input  logic            pcWriteCond,
  input  logic            pcSource,
  input  logic            irWriteEnable,
  input  logic [XLEN-1:0] aluResult,
  input  logic            aluZero,
  input  logic [XLEN-1:0] memDataOut,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] oldPc,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      instOpcode,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] mdr,
  output logic [XLEN-1:0] aluOut,
  output logic            misalignErr,
  output logic [XLEN-1:0] instrCount
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_old_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_mdr;
  logic [XLEN-1:0] r_alu_out;
  logic            r_misalign;

  logic [XLEN-1:0] w_pc_next;
  logic            w_pc_we;

  assign w_pc_next = pcSource ? r_alu_out : aluResult;
  assign w_pc_we   = pcWriteEnable | (pcWriteCond & aluZero);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_old_pc   <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_mdr      <= '0;
      r_alu_out  <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_pc_we) begin
        r_pc <= {w_pc_next[XLEN-1:2], 2'b00};
        if (w_pc_next[1:0] != 2'b00) r_misalign <= 1'b1;
      end
      // oldPc captures the pre-update PC even when the PC is written on this edge.
      if (irWriteEnable) begin
        r_instr  <= memDataOut;
        r_old_pc <= r_pc;
      end
      r_mdr     <= memDataOut;
      r_alu_out <= aluResult;
    end
  end

`ifdef PC_IR_INSTR_CNT_EN
  logic [XLEN-1:0] r_instr_cnt;

  always_ff @(posedge clk) begin
    if (rst)                r_instr_cnt <= '0;
    else if (irWriteEnable) r_instr_cnt <= r_instr_cnt + 1'b1;
  end

  assign instrCount = r_instr_cnt;
`else
  assign instrCount = '0;
`endif

  imm_gen u_imm_gen (
    .i_instr (r_instr),
    .o_imm   (imm)
  );

  assign pc          = r_pc;
  assign oldPc       = r_old_pc;
  assign instr       = r_instr;
  assign instOpcode  = r_instr[6:0];
  assign mdr         = r_mdr;
  assign aluOut      = r_alu_out;
  assign misalignErr = r_misalign;

endmodule

// File: tb/tb_pc_ir_unit.sv
// tb/tb_pc_ir_unit.sv - table-driven scoreboard bench for pc_ir_unit
module tb_pc_ir_unit;

  logic        clk = 1'b0;
  logic        rst, pcWriteEnable, pcWriteCond, pcSource, irWriteEnable, aluZero;
  logic [31:0] aluResult, memDataOut;
  logic [31:0] pc, oldPc, instr, imm, mdr, aluOut, instrCount;
  logic [6:0]  instOpcode;
  logic        misalignErr;

  always #5 clk = ~clk;

  pc_ir_unit #(.RESET_PC(32'h100)) dut (
    .clk           (clk),
    .rst           (rst),
    .pcWriteEnable (pcWriteEnable),
    .pcWriteCond   (pcWriteCond),
    .pcSource      (pcSource),
    .irWriteEnable (irWriteEnable),
    .aluResult     (aluResult),
    .aluZero       (aluZero),
    .memDataOut    (memDataOut),
    .pc            (pc),
    .oldPc         (oldPc),
    .instr         (instr),
    .instOpcode    (instOpcode),
    .imm           (imm),
    .mdr           (mdr),
    .aluOut        (aluOut),
    .misalignErr   (misalignErr),
    .instrCount    (instrCount)
  );

  typedef struct {
    logic        rst, pwe, pwc, psrc, irwe, zero;
    logic [31:0] alu_res, mem;
    logic [31:0] e_pc, e_old, e_instr, e_imm, e_aluout, e_mdr;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc, old, instr, imm, aluout, mdr, cnt;
    logic        mis;
  } exp_t;

  vec_t  vecs[12];
  exp_t  sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  logic [31:0] cnt_model = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic pwe, input logic pwc, input logic psrc,
                              input logic irwe, input logic z, input logic [31:0] ar, input logic [31:0] m,
                              input logic [31:0] epc, input logic [31:0] eold, input logic [31:0] ei,
                              input logic [31:0] eimm, input logic [31:0] eao, input logic [31:0] emdr,
                              input logic emis);
    vec_t v;
    v.rst = r; v.pwe = pwe; v.pwc = pwc; v.psrc = psrc; v.irwe = irwe; v.zero = z;
    v.alu_res = ar; v.mem = m;
    v.e_pc = epc; v.e_old = eold; v.e_instr = ei; v.e_imm = eimm;
    v.e_aluout = eao; v.e_mdr = emdr; v.e_mis = emis;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; pcWriteEnable = v.pwe; pcWriteCond = v.pwc; pcSource = v.psrc;
    irWriteEnable = v.irwe; aluZero = v.zero; aluResult = v.alu_res; memDataOut = v.mem;
  endtask

  task automatic check_all(input exp_t e, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, ".pc"},     pc,                 e.pc);
    chk({t, ".oldPc"},  oldPc,              e.old);
    chk({t, ".instr"},  instr,              e.instr);
    chk({t, ".opcode"}, {25'h0, instOpcode}, {25'h0, e.instr[6:0]});
    chk({t, ".imm"},    imm,                e.imm);
    chk({t, ".aluOut"}, aluOut,             e.aluout);
    chk({t, ".mdr"},    mdr,                e.mdr);
    chk({t, ".mis"},    {31'h0, misalignErr}, {31'h0, e.mis});
    chk({t, ".cnt"},    instrCount,         e.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //           rst pwe pwc src irw z  aluRes        mem            pc            oldPc         instr         imm           aluOut        mdr           mis
    vecs[0]  = mk(0, 1, 0, 0, 1, 0, 32'h104,      32'h0041_2083, 32'h104,      32'h100,      32'h0041_2083, 32'h4,        32'h104,      32'h0041_2083, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 32'hF8,       32'h0,         32'h104,      32'h100,      32'h0041_2083, 32'h4,        32'hF8,       32'h0,         0);
    vecs[2]  = mk(0, 0, 1, 1, 0, 0, 32'hF8,       32'h0,         32'h104,      32'h100,      32'h0041_2083, 32'h4,        32'hF8,       32'h0,         0);
    vecs[3]  = mk(0, 0, 1, 1, 0, 1, 32'h0,        32'h0,         32'hF8,       32'h100,      32'h0041_2083, 32'h4,        32'h0,        32'h0,         0);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0, 32'h0,        32'h8000_0FA3, 32'hF8,       32'hF8,       32'h8000_0FA3, 32'hFFFF_F81F, 32'h0,       32'h8000_0FA3, 0);
    vecs[5]  = mk(0, 1, 1, 0, 1, 0, 32'h200,      32'h0000_0863, 32'h200,      32'hF8,       32'h0000_0863, 32'h10,       32'h200,      32'h0000_0863, 0);
    vecs[6]  = mk(0, 1, 0, 0, 0, 0, 32'h106,      32'h0000_0033, 32'h104,      32'hF8,       32'h0000_0863, 32'h10,       32'h106,      32'h0000_0033, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h104,      32'hF8,       32'h0000_0863, 32'h10,       32'h0,        32'h0,         1);
    vecs[8]  = mk(0, 0, 0, 0, 1, 0, 32'h0,        32'hFFFF_FFB3, 32'h104,      32'h104,      32'hFFFF_FFB3, 32'h0,        32'h0,        32'hFFFF_FFB3, 1);
    vecs[9]  = mk(1, 1, 1, 0, 1, 1, 32'h300,      32'h0000_1234, 32'h100,      32'h100,      32'h0000_0013, 32'h0,        32'h0,        32'h0,         0);
    vecs[10] = mk(0, 0, 0, 0, 1, 0, 32'h5,        32'hFFC0_0003, 32'h100,      32'h100,      32'hFFC0_0003, 32'hFFFF_FFFC, 32'h5,       32'hFFC0_0003, 0);
    vecs[11] = mk(0, 1, 0, 1, 0, 0, 32'h999,      32'h0,         32'h4,        32'h100,      32'hFFC0_0003, 32'hFFFF_FFFC, 32'h999,     32'h0,         1);

    rst = 1'b1; pcWriteEnable = 1'b1; pcWriteCond = 1'b0; pcSource = 1'b0;
    irWriteEnable = 1'b1; aluZero = 1'b0; aluResult = 32'h55; memDataOut = 32'h77;
    repeat (2) @(posedge clk);
    #1;
    e.pc = 32'h100; e.old = 32'h100; e.instr = 32'h13; e.imm = 32'h0;
    e.aluout = 32'h0; e.mdr = 32'h0; e.mis = 1'b0; e.cnt = 32'h0;
    check_all(e, 99);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i]);
`ifdef PC_IR_INSTR_CNT_EN
      cnt_model = vecs[i].rst ? 32'h0 : (vecs[i].irwe ? cnt_model + 32'h1 : cnt_model);
`endif
      e.pc = vecs[i].e_pc; e.old = vecs[i].e_old; e.instr = vecs[i].e_instr;
      e.imm = vecs[i].e_imm; e.aluout = vecs[i].e_aluout; e.mdr = vecs[i].e_mdr;
      e.mis = vecs[i].e_mis; e.cnt = cnt_model;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard: queue empty at vector %0d", i);
      end else begin
        check_all(sb.pop_front(), i);
      end
    end

    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sticky_mis_%0d", k), {31'h0, misalignErr}, 32'h1);
      chk($sformatf("sticky_pc_%0d", k), pc, 32'h4);
    end

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef PC_IR_INSTR_CNT_EN
    force dut.r_instr_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_instr_cnt;
`endif
    irWriteEnable = 1'b1;
    memDataOut = 32'h0000_0013;
    repeat (3) @(posedge clk);
    #1;
`ifdef PC_IR_INSTR_CNT_EN
    chk("cnt_wrap", instrCount, 32'h1);
`else
    chk("cnt_tied", instrCount, 32'h0);
`endif
    chk("cnt_misclr", {31'h0, misalignErr}, 32'h0);
    @(negedge clk);
    irWriteEnable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ir_unit.md
PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Ports, in order:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- pcWriteEnable  in  1  unconditional PC write.
- pcWriteCond  in  1  conditional (branch) PC write.
- pcSource  in  1  0 = aluResult, 1 = aluOut.
- irWriteEnable  in  1  capture the fetched instruction.
- aluResult  in  32  combinational ALU output.
- aluZero  in  1  ALU zero flag.
- memDataOut  in  32  memory read data.
- pc  out  32  current PC.
- oldPc  out  32  PC of the instruction held in IR.
- instr  out  32  instruction register (IR).
- instOpcode  out  7  instr[6:0], to the control FSM.
- imm  out  32  sign-extended immediate decoded from IR.
- mdr  out  32  memory data register.
- aluOut  out  32  registered ALU result.
- misalignErr  out  1  sticky misaligned-PC flag.
- instrCount  out  32  fetched-instruction counter.

Function
REQ-003 PC write value SHALL be aluResult when pcSource=0, else aluOut.
REQ-004 pc SHALL load the write value when pcWriteEnable=1, or when pcWriteCond=1 and aluZero=1; otherwise it holds.
REQ-005 When pcWriteEnable=1 and pcWriteCond=1 in the same cycle, the unconditional write SHALL win; the outcome is identical.
REQ-006 Bits [1:0] of every value loaded into pc SHALL be forced to 2'b00.
REQ-007 If a written value has bits [1:0] != 0, misalignErr SHALL set on that edge and stay set until reset.
REQ-008 On irWriteEnable=1, instr SHALL load memDataOut and oldPc SHALL load the pre-update pc. This holds even when pc is written on the same edge.
REQ-009 instr and oldPc SHALL hold when irWriteEnable=0.
REQ-010 mdr SHALL load memDataOut on every cycle.
REQ-011 aluOut SHALL load aluResult on every cycle.
REQ-012 instOpcode SHALL equal instr[6:0] combinationally, with zero added latency.
REQ-013 imm SHALL be combinational from instr:
- opcode 7'h03: I-type, instr[31:20].
- opcode 7'h23: S-type, {instr[31:25], instr[11:7]}.
- opcode 7'h63: B-type, {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- all three sign-extended from instr[31].
- any other opcode: 32'h0.
REQ-014 Latency: every registered output SHALL reflect its inputs one clock edge after the enable is sampled.

Reset
REQ-015 With rst=1 at a rising edge, outputs SHALL take these values; rst SHALL take priority over every enable:
- pc = RESET_PC.
- oldPc = RESET_PC.
- instr = 32'h0000_0013 (NOP).
- mdr = 0.
- aluOut = 0.
- misalignErr = 0.
- instrCount = 0.
REQ-016 Reset asserted mid-branch (pcWriteCond=1, aluZero=1) SHALL discard the branch.

Configuration
REQ-017 Macro PC_IR_INSTR_CNT_EN:
- defined: instrCount SHALL increment by 1 on each edge with irWriteEnable=1 and rst=0, wrapping 32'hFFFF_FFFF to 0.
- undefined: the counter SHALL not exist and instrCount SHALL be tied to 32'h0.
- the port SHALL exist in both builds.

Structure
REQ-018 The shared package riscv_core_pkg SHALL hold:
- XLEN = 32.
- opcode constants OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_BRANCH = 7'h63.
- NOP_INSTR = 32'h0000_0013.
REQ-019 Immediate decode SHALL be one combinational sub-module, imm_gen. All state stays in pc_ir_unit.

Verification
REQ-020 Reset: assert rst for 2 cycles with RESET_PC = 32'h100 -> pc = 32'h100, instr = 32'h13, misalignErr = 0, instrCount = 0.
REQ-021 Fetch: pc = 32'h100, irWriteEnable = 1, pcWriteEnable = 1, aluResult = 32'h104, memDataOut = 32'h0041_2083 -> pc = 32'h104, oldPc = 32'h100, instOpcode = 7'h03, imm = 32'h4.
REQ-022 Branch taken / not taken: pcWriteCond = 1, pcSource = 1, aluOut = 32'h0F8:
- aluZero = 1 -> pc = 32'h0F8.
- aluZero = 0 -> pc unchanged.
REQ-023 Misalign: pcWriteEnable = 1, aluResult = 32'h0000_0106 -> pc = 32'h104, misalignErr = 1 and stays 1 for the next 10 cycles.
REQ-024 Simultaneous events: pcWriteEnable = 1 and pcWriteCond = 1 with aluZero = 0, aluResult = 32'h200 -> pc = 32'h200. With rst = 1 in the same cycle -> pc = RESET_PC.
REQ-025 Counter, with PC_IR_INSTR_CNT_EN defined: preload 32'hFFFF_FFFE, then 3 fetches -> instrCount = 32'h1. Without the macro -> instrCount stays 0.
